// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: EXE_CMD encodings, NZCV bit indices, operand field widths
// and the control-bit bundle carried from decode into execute.
package id_ex_stage_reg_pkg;

    localparam int SHIFT_OPERAND_W = 12;
    localparam int SIGNED_IMM_W    = 24;
    localparam int REG_ADDR_W      = 4;
    localparam int SR_W            = 4;
    localparam int EXE_CMD_W       = 4;

    // NZCV positions inside the status-register field
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef enum logic [EXE_CMD_W-1:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } ctrl_t;

    // A bubble must never write back, touch memory, branch or set flags.
    function automatic ctrl_t gate_ctrl(input logic valid, input ctrl_t ctrl);
        return valid ? ctrl : '0;
    endfunction

    function automatic logic uses_mem_offset(input logic mem_r_en, input logic mem_w_en);
        return mem_r_en | mem_w_en;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush (bubble), freeze (hold) and a saturating freeze counter.
// Optional forwarding source fields are enabled with the macro ID_EX_FORWARDING_EN.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       flush,

    input  logic                       valid_in,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]          val_rn_in,
    input  logic [DATA_W-1:0]          val_rm_in,
    input  logic                       imm_in,
    input  logic [SHIFT_OPERAND_W-1:0] shift_operand_in,
    input  logic [SIGNED_IMM_W-1:0]    signed_imm_24_in,
    input  logic [REG_ADDR_W-1:0]      dest_in,
    input  logic [SR_W-1:0]            sr_in,
    input  logic [EXE_CMD_W-1:0]       exe_cmd_in,
    input  logic                       mem_r_en_in,
    input  logic                       mem_w_en_in,
    input  logic                       wb_en_in,
    input  logic                       b_in,
    input  logic                       s_in,
`ifdef ID_EX_FORWARDING_EN
    input  logic [REG_ADDR_W-1:0]      src1_in,
    input  logic [REG_ADDR_W-1:0]      src2_in,
    output logic [REG_ADDR_W-1:0]      src1_out,
    output logic [REG_ADDR_W-1:0]      src2_out,
`endif

    output logic                       valid_out,
    output logic [DATA_W-1:0]          pc_out,
    output logic [DATA_W-1:0]          val_rn_out,
    output logic [DATA_W-1:0]          val_rm_out,
    output logic                       imm_out,
    output logic [SHIFT_OPERAND_W-1:0] shift_operand_out,
    output logic [SIGNED_IMM_W-1:0]    signed_imm_24_out,
    output logic [REG_ADDR_W-1:0]      dest_out,
    output logic [SR_W-1:0]            sr_out,
    output logic [EXE_CMD_W-1:0]       exe_cmd_out,
    output logic                       mem_r_en_out,
    output logic                       mem_w_en_out,
    output logic                       wb_en_out,
    output logic                       b_out,
    output logic                       s_out,
    output logic                       val2_sel_out,
    output logic [CNT_W-1:0]           freeze_cnt
);

    typedef struct packed {
        logic                       valid;
        logic [DATA_W-1:0]          pc;
        logic [DATA_W-1:0]          val_rn;
        logic [DATA_W-1:0]          val_rm;
        logic                       imm;
        logic [SHIFT_OPERAND_W-1:0] shift_operand;
        logic [SIGNED_IMM_W-1:0]    signed_imm_24;
        logic [REG_ADDR_W-1:0]      dest;
        logic [SR_W-1:0]            sr;
        logic [EXE_CMD_W-1:0]       exe_cmd;
        ctrl_t                      ctrl;
        logic                       val2_sel;
`ifdef ID_EX_FORWARDING_EN
        logic [REG_ADDR_W-1:0]      src1;
        logic [REG_ADDR_W-1:0]      src2;
`endif
    } stage_t;

    stage_t stage_d;
    stage_t stage_q;
    ctrl_t  ctrl_in;
    logic   freeze_hold;

    assign ctrl_in = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                       b: b_in, s: s_in};

    // NOTE: assign a default to the whole struct first so no field can ever infer a latch.
    always_comb begin
        stage_d               = '0;
        stage_d.valid         = valid_in;
        stage_d.pc            = pc_in;
        stage_d.val_rn        = val_rn_in;
        stage_d.val_rm        = val_rm_in;
        stage_d.imm           = imm_in;
        stage_d.shift_operand = shift_operand_in;
        stage_d.signed_imm_24 = signed_imm_24_in;
        stage_d.dest          = dest_in;
        stage_d.sr            = sr_in;
        stage_d.exe_cmd       = exe_cmd_in;
        stage_d.ctrl          = gate_ctrl(valid_in, ctrl_in);
        stage_d.val2_sel      = uses_mem_offset(mem_r_en_in, mem_w_en_in);
`ifdef ID_EX_FORWARDING_EN
        stage_d.src1          = src1_in;
        stage_d.src2          = src2_in;
`endif
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (flush) begin
            stage_q <= '0;
        end else if (!freeze) begin
            stage_q <= stage_d;
        end
    end

    // A flush outranks freeze, so only un-flushed stall cycles are counted.
    assign freeze_hold = freeze & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freeze_cnt <= '0;
        end else if (freeze_hold && (freeze_cnt != {CNT_W{1'b1}})) begin
            freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end

    assign valid_out         = stage_q.valid;
    assign pc_out            = stage_q.pc;
    assign val_rn_out        = stage_q.val_rn;
    assign val_rm_out        = stage_q.val_rm;
    assign imm_out           = stage_q.imm;
    assign shift_operand_out = stage_q.shift_operand;
    assign signed_imm_24_out = stage_q.signed_imm_24;
    assign dest_out          = stage_q.dest;
    assign sr_out            = stage_q.sr;
    assign exe_cmd_out       = stage_q.exe_cmd;
    assign mem_r_en_out      = stage_q.ctrl.mem_r_en;
    assign mem_w_en_out      = stage_q.ctrl.mem_w_en;
    assign wb_en_out         = stage_q.ctrl.wb_en;
    assign b_out             = stage_q.ctrl.b;
    assign s_out             = stage_q.ctrl.s;
    assign val2_sel_out      = stage_q.val2_sel;
`ifdef ID_EX_FORWARDING_EN
    assign src1_out          = stage_q.src1;
    assign src2_out          = stage_q.src2;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus randomized freeze/flush traffic
// against a behavioural model. Define ID_EX_FORWARDING_EN to also cover the src fields.
`timescale 1ns/1ps
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  sr;
        logic [3:0]  exe_cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        b;
        logic        s;
        logic        val2_sel;
`ifdef ID_EX_FORWARDING_EN
        logic [3:0]  src1;
        logic [3:0]  src2;
`endif
    } fields_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    freeze = 1'b0;
    logic    flush = 1'b0;
    fields_t din = '0;

    logic        valid_out, imm_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
    logic        val2_sel_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out, sr_out, exe_cmd_out;
    logic [15:0] freeze_cnt;
`ifdef ID_EX_FORWARDING_EN
    logic [3:0]  src1_out, src2_out;
`endif

    fields_t exp_q = '0;
    int      exp_cnt = 0;
    int      n_checks = 0;
    int      n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .valid_in          (din.valid),
        .pc_in             (din.pc),
        .val_rn_in         (din.val_rn),
        .val_rm_in         (din.val_rm),
        .imm_in            (din.imm),
        .shift_operand_in  (din.shift_operand),
        .signed_imm_24_in  (din.signed_imm_24),
        .dest_in           (din.dest),
        .sr_in             (din.sr),
        .exe_cmd_in        (din.exe_cmd),
        .mem_r_en_in       (din.mem_r_en),
        .mem_w_en_in       (din.mem_w_en),
        .wb_en_in          (din.wb_en),
        .b_in              (din.b),
        .s_in              (din.s),
`ifdef ID_EX_FORWARDING_EN
        .src1_in           (din.src1),
        .src2_in           (din.src2),
        .src1_out          (src1_out),
        .src2_out          (src2_out),
`endif
        .valid_out         (valid_out),
        .pc_out            (pc_out),
        .val_rn_out        (val_rn_out),
        .val_rm_out        (val_rm_out),
        .imm_out           (imm_out),
        .shift_operand_out (shift_operand_out),
        .signed_imm_24_out (signed_imm_24_out),
        .dest_out          (dest_out),
        .sr_out            (sr_out),
        .exe_cmd_out       (exe_cmd_out),
        .mem_r_en_out      (mem_r_en_out),
        .mem_w_en_out      (mem_w_en_out),
        .wb_en_out         (wb_en_out),
        .b_out             (b_out),
        .s_out             (s_out),
        .val2_sel_out      (val2_sel_out),
        .freeze_cnt        (freeze_cnt)
    );

    function automatic fields_t observe();
        fields_t o;
        o = '0;
        o.valid = valid_out;         o.pc = pc_out;
        o.val_rn = val_rn_out;       o.val_rm = val_rm_out;
        o.imm = imm_out;             o.shift_operand = shift_operand_out;
        o.signed_imm_24 = signed_imm_24_out;
        o.dest = dest_out;           o.sr = sr_out;
        o.exe_cmd = exe_cmd_out;     o.mem_r_en = mem_r_en_out;
        o.mem_w_en = mem_w_en_out;   o.wb_en = wb_en_out;
        o.b = b_out;                 o.s = s_out;
        o.val2_sel = val2_sel_out;
`ifdef ID_EX_FORWARDING_EN
        o.src1 = src1_out;           o.src2 = src2_out;
`endif
        return o;
    endfunction

    // Reference behaviour of one clock edge, straight from the stage rules.
    task automatic model_edge(input logic fr, input logic fl);
        if (fl) begin
            exp_q = '0;
        end else if (!fr) begin
            exp_q = din;
            exp_q.val2_sel = din.mem_r_en | din.mem_w_en;
            if (!din.valid) begin
                exp_q.wb_en = 1'b0; exp_q.mem_r_en = 1'b0; exp_q.mem_w_en = 1'b0;
                exp_q.b = 1'b0;     exp_q.s = 1'b0;
            end
        end
        if (fr && !fl && exp_cnt < 65535) exp_cnt++;
    endtask

    task automatic rand_din();
        din.valid         = ($urandom_range(0, 3) != 0);
        din.pc            = $urandom;
        din.val_rn        = $urandom;
        din.val_rm        = $urandom;
        din.imm           = 1'($urandom);
        din.shift_operand = 12'($urandom);
        din.signed_imm_24 = 24'($urandom);
        din.dest          = 4'($urandom);
        din.sr            = 4'($urandom);
        din.exe_cmd       = 4'($urandom);
        din.mem_r_en      = 1'($urandom);
        din.mem_w_en      = 1'($urandom);
        din.wb_en         = 1'($urandom);
        din.b             = 1'($urandom);
        din.s             = 1'($urandom);
        din.val2_sel      = 1'b0;
`ifdef ID_EX_FORWARDING_EN
        din.src1          = 4'($urandom);
        din.src2          = 4'($urandom);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply the current inputs for one edge with the given controls and advance the model.
    task automatic step(input logic fr, input logic fl);
        freeze = fr;
        flush  = fl;
        model_edge(fr, fl);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        exp_q = '0;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        fields_t obs;
        rst = 1'b1;
        #2;
        obs = observe();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", obs);
        end
        n_checks++;
        if (freeze_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h, want 0", freeze_cnt);
        end
        do_reset();
    endtask

    task automatic test_load();
        fields_t obs;
        din = '0;
        din.valid = 1'b1;
        din.pc = 32'h0000_0010;
        din.val_rm = 32'hDEAD_BEEF;
        din.mem_r_en = 1'b1;
        step(1'b0, 1'b0);
        n_checks++;
        if (pc_out !== 32'h10 || val_rm_out !== 32'hDEADBEEF || val2_sel_out !== 1'b1) begin
            n_fail++;
            $display("FAIL load_directed: pc %h val_rm %h val2_sel %b, want 10 deadbeef 1",
                     pc_out, val_rm_out, val2_sel_out);
        end
        // A bubble entering the stage must drop its control bits.
        din = '0;
        din.pc = 32'h1234_5678;
        din.wb_en = 1'b1; din.mem_w_en = 1'b1; din.b = 1'b1; din.s = 1'b1;
        step(1'b0, 1'b0);
        obs = observe();
        n_checks++;
        if (wb_en_out !== 1'b0 || mem_w_en_out !== 1'b0 || b_out !== 1'b0 || s_out !== 1'b0
            || obs !== exp_q) begin
            n_fail++;
            $display("FAIL load_bubble: got %h, want %h", obs, exp_q);
        end
        for (int i = 0; i < 20; i++) begin
            rand_din();
            step(1'b0, 1'b0);
            obs = observe();
            n_checks++;
            if (obs !== exp_q) begin
                n_fail++;
                $display("FAIL load_random[%0d]: got %h, want %h", i, obs, exp_q);
            end
        end
    endtask

    task automatic test_freeze();
        fields_t obs, held;
        do_reset();
        rand_din();
        din.valid = 1'b1;
        step(1'b0, 1'b0);
        held = observe();
        for (int i = 0; i < 3; i++) begin
            rand_din();
            step(1'b1, 1'b0);
            obs = observe();
            n_checks++;
            if (obs !== held || obs !== exp_q) begin
                n_fail++;
                $display("FAIL freeze_hold[%0d]: got %h, want %h", i, obs, held);
            end
        end
        n_checks++;
        if (freeze_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL freeze_cnt: got %0d, want 3", freeze_cnt);
        end
    endtask

    task automatic test_flush();
        fields_t obs;
        logic [15:0] cnt_before;
        cnt_before = 16'(exp_cnt);
        rand_din();
        din.valid = 1'b1;
        din.wb_en = 1'b1;
        step(1'b1, 1'b1);
        obs = observe();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL flush_outputs: got %h, want 0", obs);
        end
        n_checks++;
        if (freeze_cnt !== cnt_before) begin
            n_fail++;
            $display("FAIL flush_cnt: got %0d, want %0d", freeze_cnt, cnt_before);
        end
    endtask

    task automatic test_random_mix();
        fields_t obs;
        logic fr, fl;
        for (int i = 0; i < 300; i++) begin
            rand_din();
            fr = ($urandom_range(0, 9) < 3);
            fl = ($urandom_range(0, 9) == 0);
            step(fr, fl);
            obs = observe();
            n_checks++;
            if (obs !== exp_q || freeze_cnt !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL random_mix[%0d]: got %h cnt %0d, want %h cnt %0d",
                         i, obs, freeze_cnt, exp_q, exp_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        fields_t obs;
        rand_din();
        din.valid = 1'b1;
        din.pc = din.pc | 32'h1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #2;
        obs = observe();
        n_checks++;
        if (obs !== '0 || freeze_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h cnt %0d, want 0 cnt 0", obs, freeze_cnt);
        end
        exp_q = '0;
        exp_cnt = 0;
        rst = 1'b0;
        rand_din();
        step(1'b0, 1'b0);
        obs = observe();
        n_checks++;
        if (obs !== exp_q || freeze_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_release_load: got %h, want %h", obs, exp_q);
        end
    endtask

`ifdef ID_EX_FORWARDING_EN
    task automatic test_forwarding();
        din.src1 = 4'hA;
        din.src2 = 4'h3;
        step(1'b0, 1'b0);
        n_checks++;
        if (src1_out !== 4'hA || src2_out !== 4'h3) begin
            n_fail++;
            $display("FAIL fwd_load: src1 %h src2 %h, want a 3", src1_out, src2_out);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (src1_out !== 4'h0 || src2_out !== 4'h0) begin
            n_fail++;
            $display("FAIL fwd_flush: src1 %h src2 %h, want 0 0", src1_out, src2_out);
        end
    endtask
`endif

    task automatic test_saturation();
        fields_t obs;
        do_reset();
        for (int i = 0; i < 16'hFFFE; i++) step(1'b1, 1'b0);
        n_checks++;
        if (freeze_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_preload: got %h, want fffe", freeze_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            rand_din();
            step(1'b1, 1'b0);
            obs = observe();
            n_checks++;
            if (freeze_cnt !== 16'(exp_cnt) || obs !== exp_q) begin
                n_fail++;
                $display("FAIL sat_step[%0d]: cnt %h, want %h", i, freeze_cnt, 16'(exp_cnt));
            end
        end
        n_checks++;
        if (freeze_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_final: got %h, want ffff", freeze_cnt);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_load();
        test_freeze();
        test_flush();
        test_random_mix();
        test_async_reset();
`ifdef ID_EX_FORWARDING_EN
        test_forwarding();
`endif
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of PC and register-value fields.
REQ-002 SHALL have parameter CNT_W, default 16: width of the freeze-cycle counter.
REQ-003 SHALL have port clk, input, 1: single rising-edge clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports freeze and flush, input, 1 each: hazard stall hold and branch-taken bubble insert.
REQ-006 SHALL have inputs valid_in 1, pc_in DATA_W, val_rn_in DATA_W, val_rm_in DATA_W, imm_in 1, shift_operand_in 12, signed_imm_24_in 24, dest_in 4, sr_in 4 (NZCV), exe_cmd_in 4, mem_r_en_in 1, mem_w_en_in 1, wb_en_in 1, b_in 1, s_in 1: decoded ID-stage fields.
REQ-007 SHALL have one registered output per REQ-006 input, named with suffix _out instead of _in, same width.
REQ-008 SHALL have output val2_sel_out, 1: registered (mem_r_en_in | mem_w_en_in); selects the load/store offset path in the EX operand generator.
REQ-009 SHALL have output freeze_cnt, CNT_W: count of cycles held by freeze.

Function
REQ-010 SHALL update all _out fields and val2_sel_out on the rising clk edge only; latency one cycle, no combinational input-to-output path.
REQ-011 SHALL apply priority per edge: rst > flush > freeze > load.
REQ-012 On load (no flush, no freeze), SHALL capture every _in value into its _out register and capture val2_sel_out per REQ-008.
REQ-013 On flush, SHALL clear all outputs (datapath fields, control bits, valid_out, val2_sel_out) to zero, inserting a bubble regardless of freeze.
REQ-014 On freeze without flush, SHALL hold every output at its previous value.
REQ-015 SHALL increment freeze_cnt by 1 on each edge where freeze=1 and flush=0, saturating at all-ones (no wrap).
REQ-016 SHALL leave freeze_cnt unchanged by flush.
REQ-017 SHALL treat a bubble (valid_out=0) as carrying wb_en_out=0, mem_r_en_out=0, mem_w_en_out=0, b_out=0, s_out=0.
REQ-018 SHALL pass shift_operand_in and imm_in bit-exact; no decoding of shift or rotate fields in this block.

Reset
REQ-019 While rst=1, SHALL asynchronously force every output, including freeze_cnt, to zero.
REQ-020 SHALL load normally on the first clk edge after rst deasserts; reset mid-freeze discards the held instruction.

Configuration
REQ-021 With macro ID_EX_FORWARDING_EN defined, SHALL add inputs src1_in and src2_in (4 bits each) and registered outputs src1_out and src2_out, following REQ-010 to REQ-014 and REQ-019, for the forwarding unit.
REQ-022 Without ID_EX_FORWARDING_EN, SHALL omit those ports entirely; all other behaviour is identical.

Structure
REQ-023 SHALL take the EXE_CMD encodings, the NZCV bit indices and the shift-operand field widths (12, 24) from the shared pipeline package.
REQ-024 SHALL be implemented as a single module with no sub-modules; the freeze counter is inline logic.

Verification
REQ-025 Load: valid_in=1, pc_in=0x0000_0010, val_rm_in=0xDEAD_BEEF, mem_r_en_in=1, then one edge -> pc_out=0x10, val_rm_out=0xDEADBEEF, val2_sel_out=1.
REQ-026 Freeze: hold freeze=1 for 3 edges while changing inputs -> outputs unchanged and freeze_cnt=3.
REQ-027 Flush beats freeze: flush=1, freeze=1, wb_en_in=1 -> all outputs 0 and freeze_cnt unchanged.
REQ-028 Saturation: preload 0xFFFE, then 3 freeze edges -> freeze_cnt=0xFFFF.
REQ-029 Async reset: assert rst between edges with outputs nonzero -> all outputs 0 before the next edge; first edge after release loads inputs.
REQ-030 With ID_EX_FORWARDING_EN defined: src1_in=4'hA, src2_in=4'h3, one load edge -> src1_out=4'hA, src2_out=4'h3; a flush edge -> both 0.
